// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types for the APB3 master bridge.
//   AW, DW       : request address width (MSB = slave select) and data width
//   apb_state_e  : bridge FSM states
//   apb_req_t    : one latched request (address, write data, direction)
//   make_req()   : builds a request from the requester's inputs
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int AW = 9;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          write;
    } apb_req_t;

    // The requester supplies separate read and write addresses; the direction
    // picks which one is meaningful for this transfer.
    function automatic apb_req_t make_req(
        input logic          write,
        input logic [AW-1:0] rd_addr,
        input logic [AW-1:0] wr_addr,
        input logic [DW-1:0] wdata
    );
        apb_req_t req;
        req.addr  = write ? wr_addr : rd_addr;
        req.wdata = wdata;
        req.write = write;
        return req;
    endfunction

endpackage

// File: rtl/apb_wdog_cnt.sv
// -----------------------------------------------------------------------------
// apb_wdog_cnt
// Watchdog for stalled APB accesses. Counts enabled cycles from a clear and
// flags expiry once TIMEOUT-1 has been reached; the count saturates there.
//   clk     in  clock, rising edge
//   rst     in  synchronous reset, active-high
//   clr     in  restart the count at zero (takes priority over en)
//   en      in  count this cycle
//   expired out count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module apb_wdog_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: cnt_d gets a default before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of the order blocks are evaluated in.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// APB3 master stage. Latches a request from the master-control side, runs the
// SETUP/ACCESS handshake to one of two slaves (address MSB selects PSEL2) and
// returns read data. A watchdog aborts an access stalled for TIMEOUT cycles.
//   PCLK, PRESET              clock; synchronous active-high reset
//   transfer, READ_WRITE      request valid (level) and direction (1 = write)
//   apb_read_paddr/_write_paddr/apb_write_data   request payload
//   apb_read_data_out         last captured read data
//   xfer_done, xfer_err       registered completion pulse and its error flag
//   PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA   APB master outputs
//   PRDATA, PREADY, PSLVERR   APB slave responses
// -----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          transfer,
    input  logic          READ_WRITE,
    input  logic [AW-1:0] apb_read_paddr,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    output logic [DW-1:0] apb_read_data_out,
    output logic          xfer_done,
    output logic          xfer_err,
    output logic          PSEL1,
    output logic          PSEL2,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-2:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    apb_state_e    state_q, state_d;
    apb_req_t      req_q, req_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          bus_active, access_phase;
    logic          wd_clr, wd_en, wd_expired;

    apb_wdog_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (PCLK),
        .rst     (PRESET),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        bus_active   = 1'b0;
        access_phase = 1'b0;
        wd_clr       = 1'b0;
        wd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SETUP;
                    req_d   = make_req(READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data);
                end
            end

            SETUP: begin
                bus_active = 1'b1;
                wd_clr     = 1'b1;  // watchdog starts from zero in the first ACCESS cycle
                state_d    = ACCESS;
            end

            ACCESS: begin
                bus_active   = 1'b1;
                access_phase = 1'b1;
                if (PREADY) begin
                    // Read data is captured even on PSLVERR; the requester sees xfer_err.
                    if (!req_q.write) begin
                        rdata_d = PRDATA;
                    end
                    done_d = 1'b1;
                    err_d  = PSLVERR;
                    // A still-high transfer here is the next request: go straight
                    // to SETUP so back-to-back transfers have no IDLE bubble.
                    if (transfer) begin
                        state_d = SETUP;
                        req_d   = make_req(READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_expired) begin
                        // Abort always parks in IDLE, even if transfer is high.
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign PSEL1             = bus_active & ~req_q.addr[AW-1];
    assign PSEL2             = bus_active &  req_q.addr[AW-1];
    assign PENABLE           = access_phase;
    assign PWRITE            = req_q.write;
    assign PADDR             = req_q.addr[AW-2:0];
    assign PWDATA            = req_q.wdata;
    assign apb_read_data_out = rdata_q;
    assign xfer_done         = done_q;
    assign xfer_err          = err_q;

    a_psel_onehot: assert property (@(posedge PCLK) disable iff (PRESET)
        !(PSEL1 && PSEL2));

    a_penable_needs_psel: assert property (@(posedge PCLK) disable iff (PRESET)
        PENABLE |-> (PSEL1 || PSEL2));

    a_bus_stable: assert property (@(posedge PCLK) disable iff (PRESET)
        (state_q == ACCESS) |-> $stable({PADDR, PWRITE, PWDATA}));

    a_paddr_known: assert property (@(posedge PCLK) disable iff (PRESET)
        (PSEL1 || PSEL2) |-> !$isunknown(PADDR));

endmodule
